// File: rtl/nios_system_gpio_ctrl_if.sv
// Avalon-MM slave bus bundle for the Nios GPIO controller.
// Word addressed, zero wait state, combinational readdata.
interface nios_system_gpio_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_system_gpio_ctrl.sv
// Nios GPIO: direction, set/clr/tgl, synced inputs, edge capture, irq.
// Define NIOS_GPIO_ANY_EDGE_EN to capture falling edges as well.
module nios_system_gpio_ctrl #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nios_system_gpio_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic [WIDTH-1:0]        out_port,
  output logic [WIDTH-1:0]        oe_port,
  output logic                    irq
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_CAP  = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;
  localparam logic [2:0] A_TGL  = 3'd6;
  localparam logic [2:0] A_RAW  = 3'd7;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] in_sync_q, in_sync_d;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_w;
  logic [WIDTH-1:0] rd_w;
  logic [31:0]      rd32;
  logic             wr_en;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign wd    = bus.writedata[WIDTH-1:0];

  // in_prev is in_sync delayed one cycle, i.e. in_sync_q seen from
  // in_sync_d; comparing next-state values lets capture land with in_sync.
  assign sync1_d   = in_port;
  assign in_sync_d = sync1_q;

`ifdef NIOS_GPIO_ANY_EDGE_EN
  assign edge_w = in_sync_d ^ in_sync_q;
`else
  assign edge_w = in_sync_d & ~in_sync_q;
`endif

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en) begin
      case (bus.address)
        A_DATA:  out_d  = wd;
        A_DIR:   dir_d  = wd;
        A_MASK:  mask_d = wd;
        A_CAP:   clr    = wd;
        A_SET:   out_d  = out_q | wd;
        A_CLR:   out_d  = out_q & ~wd;
        A_TGL:   out_d  = out_q ^ wd;
        default: ;
      endcase
    end
    // a fresh edge beats a same-cycle clear
    cap_d = (cap_q & ~clr) | edge_w;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= RESET_OUT;
      dir_q     <= RESET_DIR;
      mask_q    <= '0;
      cap_q     <= '0;
      sync1_q   <= '0;
      in_sync_q <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      sync1_q   <= sync1_d;
      in_sync_q <= in_sync_d;
    end
  end

  always_comb begin
    rd_w = '0;
    unique case (bus.address)
      A_DATA: rd_w = (dir_q & out_q) | (~dir_q & in_sync_q);
      A_DIR:  rd_w = dir_q;
      A_MASK: rd_w = mask_q;
      A_CAP:  rd_w = cap_q;
      A_SET:  rd_w = '0;
      A_CLR:  rd_w = '0;
      A_TGL:  rd_w = '0;
      A_RAW:  rd_w = in_sync_q;
    endcase
  end

  always_comb begin
    rd32 = '0;
    rd32[WIDTH-1:0] = rd_w;
  end

  assign bus.readdata = rd32;
  assign out_port     = out_q;
  assign oe_port      = dir_q;
  assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_system_gpio_ctrl.sv
// Self-checking bench for nios_system_gpio_ctrl (WIDTH=8).
// Directed scenarios plus randomized traffic against a register model.
module tb_nios_system_gpio_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic [7:0] oe_port;
  logic       irq;

  nios_system_gpio_ctrl_if bus();

  nios_system_gpio_ctrl #(
    .WIDTH(8),
    .RESET_OUT(8'hA5),
    .RESET_DIR(8'hFF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .in_port(in_port),
    .out_port(out_port),
    .oe_port(oe_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: registers plus the two most recent pin samples.
  logic [7:0] m_out, m_dir, m_mask, m_cap;
  logic [7:0] m_s1, m_sy;

  task automatic model_reset();
    m_out  = 8'hA5;
    m_dir  = 8'hFF;
    m_mask = 8'h00;
    m_cap  = 8'h00;
    m_s1   = 8'h00;
    m_sy   = 8'h00;
  endtask

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    logic [7:0] v;
    case (a)
      3'd0:    v = (m_dir & m_out) | (~m_dir & m_sy);
      3'd1:    v = m_dir;
      3'd2:    v = m_mask;
      3'd3:    v = m_cap;
      3'd7:    v = m_sy;
      default: v = 8'h00;
    endcase
    return {24'h0, v};
  endfunction

  function automatic logic exp_irq();
    return |(m_cap & m_mask);
  endfunction

  // One clock: drive bus/pin, advance model, settle #1 past the edge.
  task automatic do_cycle(input logic cs, input logic wn,
                          input logic [2:0] a, input logic [31:0] d,
                          input logic [7:0] pin);
    logic [7:0] w, clrm, ev;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = d;
    in_port        = pin;
    w    = d[7:0];
    clrm = 8'h00;
    if (cs && !wn) begin
      case (a)
        3'd0: m_out  = w;
        3'd1: m_dir  = w;
        3'd2: m_mask = w;
        3'd3: clrm   = w;
        3'd4: m_out  = m_out | w;
        3'd5: m_out  = m_out & ~w;
        3'd6: m_out  = m_out ^ w;
        default: ;
      endcase
    end
`ifdef NIOS_GPIO_ANY_EDGE_EN
    ev = m_s1 ^ m_sy;
`else
    ev = m_s1 & ~m_sy;
`endif
    m_cap = (m_cap & ~clrm) | ev;
    m_sy  = m_s1;
    m_s1  = pin;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    in_port = 8'h00;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (out_port !== 8'hA5) begin
      n_fail++;
      $display("FAIL reset_out: got %h want a5", out_port);
    end
    n_chk++;
    if (oe_port !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_oe: got %h want ff", oe_port);
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
    rd(3'd2, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mask: got %h want 0", d);
    end
    rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cap: got %h want 0", d);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_set_clr_tgl();
    logic [7:0]  exp_o [4];
    logic [2:0]  adr   [4];
    logic [31:0] wdat  [4];
    logic [31:0] d;
    exp_o = '{8'h3C, 8'h3F, 8'h0F, 8'hF0};
    adr   = '{3'd0, 3'd4, 3'd5, 3'd6};
    wdat  = '{32'h3C, 32'h03, 32'h30, 32'hFF};
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b0, adr[i], wdat[i], 8'h00);
      n_chk++;
      if (out_port !== exp_o[i]) begin
        n_fail++;
        $display("FAIL sct_out%0d: got %h want %h", i, out_port, exp_o[i]);
      end
    end
    for (int a = 4; a < 7; a++) begin
      rd(3'(a), d);
      n_chk++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL wo_read%0d: got %h want 0", a, d);
      end
    end
  endtask

  task automatic test_dir_read();
    logic [31:0] d;
    do_cycle(1'b1, 1'b0, 3'd1, 32'h0F, 8'hA0);
    do_cycle(1'b1, 1'b0, 3'd0, 32'h05, 8'hA0);
    repeat (3) do_cycle(1'b0, 1'b1, 3'd0, 32'h0, 8'hA0);
    rd(3'd0, d);
    n_chk++;
    if (d !== 32'hA5) begin
      n_fail++;
      $display("FAIL dir_data: got %h want a5", d);
    end
    rd(3'd7, d);
    n_chk++;
    if (d !== 32'hA0) begin
      n_fail++;
      $display("FAIL in_raw: got %h want a0", d);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    repeat (3) do_cycle(1'b0, 1'b1, 3'd0, 32'h0, 8'h00);
    do_cycle(1'b1, 1'b0, 3'd3, 32'hFF, 8'h00);
    do_cycle(1'b1, 1'b0, 3'd2, 32'h01, 8'h00);
    do_cycle(1'b0, 1'b1, 3'd0, 32'h0, 8'h01);
    rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL cap_early: got %h want 0", d);
    end
    do_cycle(1'b0, 1'b1, 3'd0, 32'h0, 8'h01);
    rd(3'd3, d);
    n_chk++;
    if (d !== 32'h01) begin
      n_fail++;
      $display("FAIL cap_rise: got %h want 01", d);
    end
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
    do_cycle(1'b1, 1'b0, 3'd3, 32'h01, 8'h01);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
    repeat (2) do_cycle(1'b0, 1'b1, 3'd0, 32'h0, 8'h03);
    rd(3'd3, d);
    n_chk++;
    if (d !== 32'h02) begin
      n_fail++;
      $display("FAIL cap_masked: got %h want 02", d);
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked: got %b want 0", irq);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    repeat (3) do_cycle(1'b0, 1'b1, 3'd0, 32'h0, 8'h02);
    do_cycle(1'b1, 1'b0, 3'd3, 32'hFF, 8'h02);
    do_cycle(1'b0, 1'b1, 3'd0, 32'h0, 8'h03);
    do_cycle(1'b1, 1'b0, 3'd3, 32'h01, 8'h03);
    rd(3'd3, d);
    n_chk++;
    if (d !== 32'h01) begin
      n_fail++;
      $display("FAIL set_wins_cap: got %h want 01", d);
    end
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins_irq: got %b want 1", irq);
    end
  endtask

  task automatic test_falling();
    logic [31:0] d;
    logic [31:0] want;
    logic        want_irq;
`ifdef NIOS_GPIO_ANY_EDGE_EN
    want     = 32'h01;
    want_irq = 1'b1;
`else
    want     = 32'h00;
    want_irq = 1'b0;
`endif
    do_cycle(1'b1, 1'b0, 3'd3, 32'hFF, 8'h03);
    repeat (2) do_cycle(1'b0, 1'b1, 3'd0, 32'h0, 8'h02);
    rd(3'd3, d);
    n_chk++;
    if (d !== want) begin
      n_fail++;
      $display("FAIL fall_cap: got %h want %h", d, want);
    end
    n_chk++;
    if (irq !== want_irq) begin
      n_fail++;
      $display("FAIL fall_irq: got %b want %b", irq, want_irq);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  pin;
    logic [2:0]  ra;
    pin = in_port;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset_n = 1'b0;
        #2;
        model_reset();
        n_chk++;
        if (out_port !== 8'hA5 || oe_port !== 8'hFF || irq !== 1'b0) begin
          n_fail++;
          $display("FAIL async_reset: got out=%h oe=%h irq=%b want a5 ff 0",
                   out_port, oe_port, irq);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
      do_cycle(1'($urandom), 1'($urandom), 3'($urandom), $urandom, pin);
      n_chk++;
      if (out_port !== m_out || oe_port !== m_dir || irq !== exp_irq()) begin
        n_fail++;
        $display("FAIL rand_pins%0d: got %h %h %b want %h %h %b", i,
                 out_port, oe_port, irq, m_out, m_dir, exp_irq());
      end
      ra = 3'($urandom);
      rd(ra, d);
      n_chk++;
      if (d !== exp_rd(ra)) begin
        n_fail++;
        $display("FAIL rand_rd%0d a%0d: got %h want %h", i, ra, d, exp_rd(ra));
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_set_clr_tgl();
    test_dir_read();
    test_edge_irq();
    test_set_wins();
    test_falling();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
